// File: rtl/lbp_engine.sv
`default_nettype none
// ============================================================================
// Module   : lbp_engine
// Purpose  : 3x3 Local Binary Pattern engine with a sliding window that reuses
//            two columns per in-row step. Optional macro: LBP_STALL_EN.
// Revision : 1.0
// ============================================================================
module lbp_engine #(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int DW          = 8,
    parameter int AW          = 14,
    parameter int BORDER_ZERO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data,
`ifdef LBP_STALL_EN
    input  logic          lbp_ready,
`endif
    output logic          finish
);

    localparam bit          BZ      = (BORDER_ZERO != 0);
    localparam logic [AW-1:0] IMG_W_A = AW'(IMG_W);
    localparam logic [AW-1:0] X_MAX   = AW'(IMG_W - 1);
    localparam logic [AW-1:0] Y_MAX   = AW'(IMG_H - 1);
    localparam logic [AW-1:0] X_START = BZ ? '0 : AW'(1);
    localparam logic [AW-1:0] Y_START = BZ ? '0 : AW'(1);
    localparam logic [AW-1:0] X_END   = BZ ? AW'(IMG_W - 1) : AW'(IMG_W - 2);
    localparam logic [AW-1:0] Y_END   = BZ ? AW'(IMG_H - 1) : AW'(IMG_H - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SLIDE  = 3'd2,
        S_WRITE  = 3'd3,
        S_BORDER = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        state_q;
    logic [AW-1:0] x_q, y_q;
    logic [3:0]    cnt_q;
    logic [1:0]    col_q, row_q;
    logic          pend_q;
    logic [1:0]    pcol_q, prow_q;
    logic [DW-1:0] win_q [3][3];   // [column][row], column 0 = x-1

    logic [DW-1:0] win_d [3][3];
    logic [7:0]    code_d;
    logic [3:0]    need;
    logic          issuing;
    logic          accept;
    logic          last_pix;
    logic [AW-1:0] nx_x, nx_y;
    logic          nx_border, nx_load;

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] px,
                                               input logic [AW-1:0] py);
        return py * IMG_W_A + px;
    endfunction

    function automatic logic [AW-1:0] win_addr(input logic [AW-1:0] px,
                                               input logic [AW-1:0] py,
                                               input logic [1:0]    col,
                                               input logic [1:0]    row);
        return pix_addr(px + AW'(col) - AW'(1), py + AW'(row) - AW'(1));
    endfunction

`ifdef LBP_STALL_EN
    assign accept = lbp_ready;
`else
    assign accept = 1'b1;
`endif

    assign need     = (state_q == S_LOAD) ? 4'd9 : 4'd3;
    assign issuing  = ((state_q == S_LOAD) || (state_q == S_SLIDE)) && (cnt_q != need);
    assign gray_req = issuing && gray_ready;

    // Window as it will look after this cycle's capture; the code is taken from it
    // so the final capture and the result register update share one cycle.
    always_comb begin
        win_d = win_q;
        if (pend_q) begin
            win_d[pcol_q][prow_q] = gray_data;
        end
        code_d[0] = (win_d[0][0] >= win_d[1][1]);
        code_d[1] = (win_d[1][0] >= win_d[1][1]);
        code_d[2] = (win_d[2][0] >= win_d[1][1]);
        code_d[3] = (win_d[0][1] >= win_d[1][1]);
        code_d[4] = (win_d[2][1] >= win_d[1][1]);
        code_d[5] = (win_d[0][2] >= win_d[1][1]);
        code_d[6] = (win_d[1][2] >= win_d[1][1]);
        code_d[7] = (win_d[2][2] >= win_d[1][1]);
    end

    always_comb begin
        last_pix = (x_q == X_END) && (y_q == Y_END);
        if (x_q == X_END) begin
            nx_x = X_START;
            nx_y = y_q + AW'(1);
        end else begin
            nx_x = x_q + AW'(1);
            nx_y = y_q;
        end
        nx_border = BZ && ((nx_x == '0) || (nx_x == X_MAX) || (nx_y == '0) || (nx_y == Y_MAX));
        nx_load   = (nx_x == AW'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pend_q    <= 1'b0;
            pcol_q    <= '0;
            prow_q    <= '0;
            gray_addr <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
            finish    <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[c][r] <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gray_ready) begin
                        x_q <= X_START;
                        y_q <= Y_START;
                        if (BZ) begin
                            state_q   <= S_BORDER;
                            lbp_valid <= 1'b1;
                            lbp_addr  <= '0;
                            lbp_data  <= '0;
                        end else begin
                            state_q   <= S_LOAD;
                            cnt_q     <= '0;
                            col_q     <= '0;
                            row_q     <= '0;
                            gray_addr <= win_addr(X_START, Y_START, 2'd0, 2'd0);
                        end
                    end
                end

                S_LOAD, S_SLIDE: begin
                    win_q  <= win_d;
                    pend_q <= 1'b0;
                    if (issuing) begin
                        if (gray_ready) begin
                            pend_q <= 1'b1;
                            pcol_q <= col_q;
                            prow_q <= row_q;
                            cnt_q  <= cnt_q + 4'd1;
                            if (row_q == 2'd2) begin
                                row_q     <= 2'd0;
                                col_q     <= col_q + 2'd1;
                                gray_addr <= win_addr(x_q, y_q, col_q + 2'd1, 2'd0);
                            end else begin
                                row_q     <= row_q + 2'd1;
                                gray_addr <= win_addr(x_q, y_q, col_q, row_q + 2'd1);
                            end
                        end
                    end else if (pend_q) begin
                        state_q   <= S_WRITE;
                        lbp_valid <= 1'b1;
                        lbp_addr  <= pix_addr(x_q, y_q);
                        lbp_data  <= code_d;
                    end
                end

                S_WRITE, S_BORDER: begin
                    if (accept) begin
                        if (last_pix) begin
                            state_q   <= S_DONE;
                            lbp_valid <= 1'b0;
                            finish    <= 1'b1;
                        end else begin
                            x_q <= nx_x;
                            y_q <= nx_y;
                            if (nx_border) begin
                                state_q   <= S_BORDER;
                                lbp_valid <= 1'b1;
                                lbp_addr  <= pix_addr(nx_x, nx_y);
                                lbp_data  <= '0;
                            end else begin
                                lbp_valid <= 1'b0;
                                cnt_q     <= '0;
                                row_q     <= '0;
                                if (nx_load) begin
                                    state_q   <= S_LOAD;
                                    col_q     <= 2'd0;
                                    gray_addr <= win_addr(nx_x, nx_y, 2'd0, 2'd0);
                                end else begin
                                    // Shift left; the right column is refetched by SLIDE.
                                    state_q   <= S_SLIDE;
                                    col_q     <= 2'd2;
                                    gray_addr <= win_addr(nx_x, nx_y, 2'd2, 2'd0);
                                    for (int r = 0; r < 3; r++) begin
                                        win_q[0][r] <= win_q[1][r];
                                        win_q[1][r] <= win_q[2][r];
                                    end
                                end
                            end
                        end
                    end
                end

                S_DONE: begin
                    finish    <= 1'b1;
                    lbp_valid <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lbp_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lbp_engine
// Purpose  : Randomised self-checking bench for lbp_engine against a raster
//            reference model (three geometries, optional LBP_STALL_EN).
// Revision : 1.0
// ============================================================================
module tb_lbp_engine;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int ND = 3;

    int WS  [ND] = '{9, 4, 3};
    int HS  [ND] = '{6, 4, 3};
    int BZS [ND] = '{0, 1, 0};
    int DX  [8]  = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int DY  [8]  = '{-1, -1, -1, 0, 0, 1, 1, 1};

    logic          clk = 1'b0;
    logic          reset;
    logic          gray_ready [ND];
    logic          gray_req   [ND];
    logic [AW-1:0] gray_addr  [ND];
    logic [DW-1:0] gray_data  [ND];
    logic          lbp_valid  [ND];
    logic [AW-1:0] lbp_addr   [ND];
    logic [7:0]    lbp_data   [ND];
    logic          lbp_ready  [ND];
    logic          finish     [ND];

    logic [7:0] img      [ND][256];
    logic [7:0] got_data [256];

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    v;
    } wr_t;
    wr_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lbp_engine #(.IMG_W(9), .IMG_H(6), .DW(DW), .AW(AW), .BORDER_ZERO(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .gray_ready(gray_ready[0]), .gray_req(gray_req[0]), .gray_addr(gray_addr[0]),
        .gray_data(gray_data[0]), .lbp_valid(lbp_valid[0]), .lbp_addr(lbp_addr[0]),
        .lbp_data(lbp_data[0]),
`ifdef LBP_STALL_EN
        .lbp_ready(lbp_ready[0]),
`endif
        .finish(finish[0])
    );

    lbp_engine #(.IMG_W(4), .IMG_H(4), .DW(DW), .AW(AW), .BORDER_ZERO(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .gray_ready(gray_ready[1]), .gray_req(gray_req[1]), .gray_addr(gray_addr[1]),
        .gray_data(gray_data[1]), .lbp_valid(lbp_valid[1]), .lbp_addr(lbp_addr[1]),
        .lbp_data(lbp_data[1]),
`ifdef LBP_STALL_EN
        .lbp_ready(lbp_ready[1]),
`endif
        .finish(finish[1])
    );

    lbp_engine #(.IMG_W(3), .IMG_H(3), .DW(DW), .AW(AW), .BORDER_ZERO(0)) u_dut2 (
        .clk(clk), .reset(reset),
        .gray_ready(gray_ready[2]), .gray_req(gray_req[2]), .gray_addr(gray_addr[2]),
        .gray_data(gray_data[2]), .lbp_valid(lbp_valid[2]), .lbp_addr(lbp_addr[2]),
        .lbp_data(lbp_data[2]),
`ifdef LBP_STALL_EN
        .lbp_ready(lbp_ready[2]),
`endif
        .finish(finish[2])
    );

    // One-cycle-latency gray memory per engine
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (gray_req[d]) gray_data[d] <= img[d][gray_addr[d]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic build_model(input int d);
        int w;
        int h;
        w = WS[d];
        h = HS[d];
        exp_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                wr_t e;
                bit  border;
                border = (x == 0) || (y == 0) || (x == w - 1) || (y == h - 1);
                e.a = AW'(y * w + x);
                e.v = 8'h00;
                if (!border) begin
                    for (int i = 0; i < 8; i++)
                        e.v[i] = (img[d][(y + DY[i]) * w + x + DX[i]] >= img[d][y * w + x]);
                end
                if (!border || BZS[d] != 0) exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < ND; d++) begin
            gray_ready[d] = 1'b1;
            lbp_ready[d]  = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("rst_gray_req", gray_req[d], 0);
            check("rst_gray_addr", gray_addr[d], 0);
            check("rst_lbp_valid", lbp_valid[d], 0);
            check("rst_lbp_addr", lbp_addr[d], 0);
            check("rst_lbp_data", lbp_data[d], 0);
            check("rst_finish", finish[d], 0);
            gray_ready[d] = 1'b0;
        end
        reset = 1'b1;
    endtask

    // gmode: 0 ready always, 1 one-on/two-off, 2 random.
    // smode: 0 sink always ready, 1 random sink, 2 first write held 5 cycles.
    task automatic run(input int d, input int gmode, input int smode,
                       input int abort_after, output bit aborted);
        int            cyc;
        int            k;
        int            last_acc;
        int            held;
        bit            fin;
        bit            bad_req;
        logic [AW-1:0] ha;
        logic [7:0]    hd;
        cyc = 0; k = 0; last_acc = -100; held = 0;
        fin = 1'b0; bad_req = 1'b0; aborted = 1'b0;
        ha = '0; hd = '0;
        for (int i = 0; i < 256; i++) got_data[i] = 8'hAA;
        build_model(d);
        while (!fin && !aborted && cyc < 20000) begin
            @(negedge clk);
            case (gmode)
                0:       gray_ready[d] = 1'b1;
                1:       gray_ready[d] = (cyc % 3 == 0);
                default: gray_ready[d] = 1'($urandom_range(0, 1));
            endcase
            lbp_ready[d] = 1'b1;
            if (smode == 1) lbp_ready[d] = ($urandom_range(0, 3) != 0);
            if (smode == 2 && lbp_valid[d] && k == 0 && held < 5) begin
                lbp_ready[d] = 1'b0;
                if (held == 0) begin
                    ha = lbp_addr[d];
                    hd = lbp_data[d];
                end else begin
                    check("stall_addr_hold", lbp_addr[d], ha);
                    check("stall_data_hold", lbp_data[d], hd);
                end
                held++;
            end
            #1;
            if (smode == 2 && lbp_valid[d] && !lbp_ready[d])
                check("stall_no_gray_req", gray_req[d], 0);
            if (gray_req[d] && !gray_ready[d]) bad_req = 1'b1;
            if (finish[d]) begin
                fin = 1'b1;
                check("finish_timing", cyc, last_acc + 1);
                check("write_count", k, exp_q.size());
                check("valid_in_done", lbp_valid[d], 0);
            end else if (lbp_valid[d] && lbp_ready[d]) begin
                if (k < exp_q.size()) begin
                    check("wr_addr", lbp_addr[d], exp_q[k].a);
                    check("wr_data", lbp_data[d], exp_q[k].v);
                end else begin
                    check("write_count", k + 1, exp_q.size());
                end
                if (smode == 2 && k == 0) check("stall_len", held, 5);
                got_data[lbp_addr[d]] = lbp_data[d];
                k++;
                last_acc = cyc;
                if (abort_after > 0 && k == abort_after) aborted = 1'b1;
            end
            cyc++;
        end
        if (!aborted) check("finish_seen", fin, 1);
        check("req_while_not_ready", bad_req, 0);
        gray_ready[d] = 1'b0;
    endtask

    task automatic fill_random(input int d, input int maxv);
        for (int i = 0; i < 256; i++) img[d][i] = 8'($urandom_range(0, maxv));
    endtask

    initial begin
        bit ab;
        reset = 1'b0;
        for (int d = 0; d < ND; d++) begin
            gray_ready[d] = 1'b0;
            lbp_ready[d]  = 1'b1;
            for (int i = 0; i < 256; i++) img[d][i] = 8'h00;
        end

        // 4x4 ramp with border writes
        for (int i = 0; i < 256; i++) img[1][i] = 8'(i);
        do_reset();
        run(1, 0, 0, 0, ab);
        check("ramp_a0", got_data[0], 8'h00);
        check("ramp_a5", got_data[5], 8'hF0);
        check("ramp_a6", got_data[6], 8'hF0);
        check("ramp_a10", got_data[10], 8'hF0);
        check("ramp_a15", got_data[15], 8'h00);

        // 3x3: bright centre, then dark centre with one darker corner
        for (int i = 0; i < 9; i++) img[2][i] = 8'd10;
        img[2][4] = 8'd20;
        do_reset();
        run(2, 0, 0, 0, ab);
        check("3x3_bright_centre", got_data[4], 8'h00);
        img[2][4] = 8'd5;
        img[2][8] = 8'd0;
        do_reset();
        run(2, 1, 0, 0, ab);
        check("3x3_dark_centre", got_data[4], 8'h7F);

        // Constant image: every neighbour equals the centre
        for (int i = 0; i < 256; i++) img[0][i] = 8'h55;
        do_reset();
        run(0, 0, 0, 0, ab);
        check("const_first", got_data[10], 8'hFF);
        check("const_last", got_data[4 * 9 + 7], 8'hFF);

        // Random images, many ties, gray_ready one-on/two-off
        fill_random(0, 3);
        do_reset();
        run(0, 1, 0, 0, ab);

        // Abort mid-image with reset, then a full restart
        fill_random(0, 255);
        do_reset();
        run(0, 2, 0, 10, ab);
        check("abort_reached", ab, 1);
        do_reset();
        run(0, 2, 0, 0, ab);

        fill_random(1, 7);
        do_reset();
        run(1, 2, 0, 0, ab);

`ifdef LBP_STALL_EN
        fill_random(0, 15);
        do_reset();
        run(0, 0, 2, 0, ab);
        fill_random(1, 15);
        do_reset();
        run(1, 2, 1, 0, ab);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lbp_engine.md
Name: lbp_engine

Overview:
- Parametrised Local Binary Pattern engine for row-major grayscale images of any size IMG_W x IMG_H.
- Reads pixels from the gray memory over a one-cycle-latency request interface and writes one 8-bit LBP code per output pixel to the result memory.
- Re-uses the previous 3x3 window, so each in-row step fetches only the new right column: 3 reads instead of 9.
- Adds two modes: border pixels either skipped or written as 0, and optional result backpressure.

Parameters:
- IMG_W, 128, image width in pixels, must be >=3
- IMG_H, 128, image height in pixels, must be >=3
- DW, 8, gray pixel width in bits
- AW, 14, address width, must satisfy 2^AW >= IMG_W*IMG_H
- BORDER_ZERO, 0, 0 = border pixels not written; 1 = border pixels written with 0x00

Ports:
- clk  in  1  clock, all flops on rising edge
- reset  in  1  asynchronous, active-low reset
- gray_ready  in  1  gray memory available; level-sensitive
- gray_req  out  1  read strobe for gray_addr this cycle
- gray_addr  out  AW  read address = y*IMG_W + x
- gray_data  in  DW  read data, valid the cycle after gray_req
- lbp_valid  out  1  write strobe for lbp_addr/lbp_data
- lbp_addr  out  AW  write address, row-major
- lbp_data  out  8  LBP code
- lbp_ready  in  1  result sink ready (present only with LBP_STALL_EN)
- finish  out  1  all results written; held until reset

Behaviour:
- Reset (reset=0): all outputs 0, window regs 0, FSM in IDLE, x=y=0. Reset mid-operation aborts immediately; no further strobes until restart.
- FSM states:
  - IDLE: wait for gray_ready=1, then go to BORDER or LOAD for the first output pixel.
  - LOAD: 9-pixel fetch at each row start.
  - SLIDE: 3-pixel fetch of the right column; window shifts left one column first.
  - WRITE: one result strobe.
  - BORDER: only when BORDER_ZERO=1; single-cycle write of 0x00, no reads.
  - DONE: finish=1, all strobes 0.
- Read issue:
  - gray_req=1 only in LOAD/SLIDE issue cycles with gray_ready=1.
  - If gray_ready=0, the issue stalls with gray_addr held and gray_req=0.
  - A capture already in flight (req issued last cycle) still completes.
- LOAD order: columns x-1, x, x+1; rows y-1, y, y+1 within each column.
- SLIDE order: (x+1,y-1), (x+1,y), (x+1,y+1).
- Timing with gray_ready continuously 1:
  - LOAD = 9 issue cycles + 1 final capture, then WRITE.
  - SLIDE = 3 + 1, then WRITE.
  - In-row throughput: 5 cycles/pixel.
- LBP code, centre c = window(x,y); bit i = 1 iff neighbour >= c, unsigned DW-bit compare:
  - bit0 (x-1,y-1), bit1 (x,y-1), bit2 (x+1,y-1)
  - bit3 (x-1,y), bit4 (x+1,y)
  - bit5 (x-1,y+1), bit6 (x,y+1), bit7 (x+1,y+1)
  - Equal values set the bit.
- WRITE: lbp_valid=1 for exactly one cycle (see LBP_STALL_EN); lbp_addr=y*IMG_W+x; lbp_data registered and stable while valid.
- Scan order, BORDER_ZERO=0:
  - Interior pixels only, x in 1..IMG_W-2, y in 1..IMG_H-2, raster order.
  - After x=IMG_W-2, go to x=1, y+1 and perform a fresh LOAD.
- Scan order, BORDER_ZERO=1:
  - All IMG_W*IMG_H addresses in raster order; rows 0 and IMG_H-1, and columns 0 and IMG_W-1, use BORDER.
  - First interior pixel in each row uses LOAD.
- Completion: finish rises the cycle after the last write is accepted (address (IMG_H-2)*IMG_W+IMG_W-2, or IMG_W*IMG_H-1 with BORDER_ZERO=1). Engine then sits in DONE.
- Address arithmetic is AW-bit unsigned; no wrap is possible given the AW constraint.

Optional Feature:
- LBP_STALL_EN defined:
  - lbp_ready port exists.
  - In WRITE/BORDER, lbp_valid, lbp_addr and lbp_data hold stable until a cycle with lbp_ready=1; the write completes in that cycle.
  - No reads are issued while stalled.
- Not defined: no lbp_ready port; every write completes in its single valid cycle.

Test Plan:
- Defaults, constant image 0x55, gray_ready=1 -> 15876 writes, all lbp_data=0xFF; first lbp_addr=129, last 16254; 48384 gray_req pulses; finish high the cycle after the last write.
- IMG_W=IMG_H=3, neighbours 10, centre 20 -> single write addr 4 data 0x00. Centre 5, neighbours 10 except (2,2)=0 -> data 0x7F.
- Defaults, random image, gray_ready toggled 1-on/2-off -> lbp_addr/lbp_data sequence identical to a golden model; gray_req never high while gray_ready=0.
- Assert reset=0 after the 300th write, release, raise gray_ready -> outputs 0 during reset; restart from addr 129 with correct codes; finish only after the full image.
- BORDER_ZERO=1, IMG_W=IMG_H=4, ramp gray=addr -> 16 writes at addrs 0..15. Border writes 0x00. Addrs 5 and 6 have centre less than or equal to the ramp neighbours at (x+1,y), (x-1,y+1), (x,y+1), (x+1,y+1), so each gets 0xF0 (bits 4-7 set).
- LBP_STALL_EN, lbp_ready low 5 cycles at the first write -> lbp_valid/addr/data held 6 cycles, no gray_req meanwhile; the next pixel then proceeds normally.
